stim_traffic_gen: RTL
=====================

Name: stim_traffic_gen

Overview:
- Synthesizable, parametrised successor to the bench-side counter/state-machine stimulus logic.
- Produces a phased pattern stream (arm wait, data burst, flag/status shift) on a valid/ready interface.
- Also produces a divided-clock-enable chain for driving SoC IO-pad inputs.
- Sits between the pad-input mux and the ASIC top, on-chip or in benches.
- Adds configurable widths and lengths, backpressure, selectable data patterns, loop and abort.

Parameters:
DATA_W, 16, output data width (LFSR mode supports 8/16/32)
IDLE_CYC, 256, cycles spent in ARM before each burst (>=1)
BURST_LEN, 65536, handshakes per burst (>=1)
FLAG_W, 4, control-flag counter width; SHIFT phase lasts 2**FLAG_W cycles
STATUS_W, 8, status shift-register width
DIV_STAGES, 3, number of divide-by-2 stages in the divider chain

Ports:
sys_clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  terminate run; highest priority after reset
loop_en  in  1  re-arm after SHIFT instead of finishing
mode  in  2  00 increment, 01 LFSR, 10 walking-one, 11 treated as 00
out_ready  in  1  sink ready
out_valid  out  1  data valid (BURST only)
out_data  out  DATA_W  pattern word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of non-looping run
flags  out  FLAG_W  control-flag counter
status  out  STATUS_W  status shift register
div_clk  out  DIV_STAGES  div_clk[k] toggles with period 2**(k+1) cycles
beat_cnt  out  32  total handshakes since reset, wraps mod 2**32

Behaviour:
- Reset (rst_n low at a sys_clk edge): state IDLE; every output and internal counter 0. Reset mid-run aborts it, with no done pulse.
- States: IDLE, ARM, BURST, SHIFT, DONE.
- Mode is latched on start. Changes to mode mid-run are ignored.
- IDLE -> ARM the cycle after start is sampled high. start in any other state is ignored.
- ARM: counts exactly IDLE_CYC cycles, then -> BURST.
  - Entering BURST loads the seed: 0 (increment), 1 (LFSR, walking-one).
- BURST: out_valid=1 every cycle.
  - out_data holds stable until out_valid&&out_ready.
  - On each handshake: out_data advances, beat_cnt increments, burst counter increments.
  - Increment mode wraps mod 2**DATA_W. Walking-one rotates left (MSB -> bit0).
  - After the BURST_LEN-th handshake -> SHIFT; out_valid is 0 from the next cycle.
- SHIFT: each cycle, flags <= flags+1 and status <= {status[STATUS_W-2:0], ^out_data}.
  - The cycle in which flags==all-ones (flags wraps to 0) is the last SHIFT cycle.
  - Exit -> ARM if loop_en, else -> DONE.
  - Phase length is exactly 2**FLAG_W cycles.
- DONE: done=1 for one cycle, then -> IDLE.
- abort high in any non-IDLE state: next cycle IDLE.
  - out_valid, out_data, flags are cleared; status and beat_cnt are retained.
  - No done pulse.
- Divider chain is free-running from reset, independent of state.
  - div_clk[0] toggles every cycle.
  - div_clk[k] toggles when div_clk[k-1:0] are all 1.

Optional Feature:
STIM_GEN_LFSR_EN
- Defined: mode 01 runs a Galois LFSR over out_data, advancing on each handshake.
  - Taps come from the package (16-bit: x^16+x^14+x^13+x^11+1; also 8 and 32).
  - Seed is 1, so the all-zero state is never reached.
- Undefined: no LFSR logic is built; mode 01 behaves exactly as mode 00.

Decomposition:
- Shared package stim_gen_pkg:
  - state enum (state_e)
  - mode encodings (MODE_INC, MODE_LFSR, MODE_WALK)
  - function lfsr_taps(int width) returning the tap mask
- One sub-module, stim_clk_div: the parametrised DIV_STAGES toggle chain with its own sync reset.
- The FSM, counters and pattern logic live in the top module.

Test Plan:
1. Reset: rst_n low 3 cycles, then high -> all outputs 0; div_clk[0..2] periods 2/4/8 cycles, with div_clk[2] first high 4 cycles after reset release.
2. IDLE_CYC=4, BURST_LEN=8, FLAG_W=4, mode 00, out_ready=1, start at cycle 0:
   - out_valid high cycles 5..12 with out_data 0..7;
   - flags 1..15,0 over cycles 13..28;
   - done at cycle 29; busy low from 30; beat_cnt=8.
3. Backpressure: out_ready low for 3 cycles while out_data=2 -> out_data holds 2 and out_valid stays 1; the next value 3 appears only after out_ready returns; total 8 beats preserved.
4. DATA_W=8, mode 10, BURST_LEN=9 -> sequence 01,02,04,08,10,20,40,80,01.
5. loop_en=1 -> after SHIFT, ARM again and out_data restarts at 0. abort asserted at the 3rd beat -> next cycle busy=0, out_valid=0, no done pulse; status and beat_cnt retained.
6. Mode 01, DATA_W=16:
   - with STIM_GEN_LFSR_EN -> 0001, then values per the package tap mask;
   - without the macro -> 0000,0001,0002...; start during BURST is ignored.

Source files
------------

// File: rtl/stim_traffic_gen_pkg.sv
// Shared types and constants for the stimulus traffic generator.
// The LFSR tap masks are only consumed when STIM_GEN_LFSR_EN is defined.
package stim_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_BURST,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam logic [1:0] MODE_INC  = 2'b00;
    localparam logic [1:0] MODE_LFSR = 2'b01;
    localparam logic [1:0] MODE_WALK = 2'b10;

    // Galois right-shift tap masks: bit (n-1) set for each x^n term.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
            16:      return 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
            32:      return 32'h8020_0003;  // x^32+x^22+x^2+x^1+1
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/stim_traffic_gen_if.sv
// Valid/ready pattern stream between the generator (master) and its sink.
interface stim_traffic_gen_if #(
    parameter int DATA_W = 16
) ();
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/stim_traffic_gen_clk_div.sv
// Free-running divide-by-2 chain: stage k toggles when all lower stages are high.
module stim_clk_div #(
    parameter int DIV_STAGES = 3
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    output logic [DIV_STAGES-1:0] div_clk
);
    logic [DIV_STAGES-1:0] div_q;
    logic [DIV_STAGES-1:0] div_d;

    // Ripple the toggle enable up the chain.
    always_comb begin
        logic carry;
        carry = 1'b1;
        div_d = div_q;
        for (int k = 0; k < DIV_STAGES; k++) begin
            div_d[k] = div_q[k] ^ carry;
            carry    = carry & div_q[k];
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end

    assign div_clk = div_q;
endmodule

// File: rtl/stim_traffic_gen.sv
// Phased pattern generator: arm wait, data burst on valid/ready, flag/status shift.
// Optional macro STIM_GEN_LFSR_EN builds the Galois LFSR pattern for mode 01;
// without it mode 01 behaves as increment.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; mode latched on start
// ST_ARM   | down-counting IDLE_CYC cycles before the burst
// ST_BURST | out_valid high; pattern advances on each handshake
// ST_SHIFT | 2**FLAG_W cycles of flag count and status parity shift
// ST_DONE  | one-cycle done pulse, then back to idle
module stim_traffic_gen
    import stim_gen_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IDLE_CYC   = 256,
    parameter int BURST_LEN  = 65536,
    parameter int FLAG_W     = 4,
    parameter int STATUS_W   = 8,
    parameter int DIV_STAGES = 3
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  loop_en,
    input  logic [1:0]            mode,
    stim_traffic_gen_if.master    out_if,
    output logic                  busy,
    output logic                  done,
    output logic [FLAG_W-1:0]     flags,
    output logic [STATUS_W-1:0]   status,
    output logic [DIV_STAGES-1:0] div_clk,
    output logic [31:0]           beat_cnt
);
    localparam int ARM_W  = $clog2(IDLE_CYC + 1);
    localparam int BCNT_W = $clog2(BURST_LEN + 1);
    localparam logic [ARM_W-1:0]  ARM_LOAD   = ARM_W'(IDLE_CYC - 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN - 1);
`ifdef STIM_GEN_LFSR_EN
    localparam logic [DATA_W-1:0] LFSR_MASK = DATA_W'(lfsr_taps(DATA_W));
`endif

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [ARM_W-1:0]    arm_q, arm_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [31:0]         beat_q, beat_d;
    logic [DATA_W-1:0]   seed, adv;
    logic                hs;

    // Pattern seed and next value for the latched mode.
    always_comb begin
        seed = '0;
        adv  = data_q + DATA_W'(1);
        if (mode_q == MODE_WALK) begin
            seed = DATA_W'(1);
            adv  = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
        end
`ifdef STIM_GEN_LFSR_EN
        else if (mode_q == MODE_LFSR) begin
            seed = DATA_W'(1);
            adv  = (data_q >> 1) ^ (data_q[0] ? LFSR_MASK : '0);
        end
`endif
    end

    // Next-state, counters and pattern update; abort outranks everything but reset.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        arm_d    = arm_q;
        bcnt_d   = bcnt_q;
        data_d   = data_q;
        flags_d  = flags_q;
        status_d = status_q;
        beat_d   = beat_q;
        hs       = (state_q == ST_BURST) && out_if.out_ready;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            data_d  = '0;
            flags_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d = ST_ARM;
                    mode_d  = mode;
                    arm_d   = ARM_LOAD;
                end
                ST_ARM: begin
                    if (arm_q == '0) begin
                        state_d = ST_BURST;
                        data_d  = seed;
                        bcnt_d  = '0;
                    end else begin
                        arm_d = arm_q - ARM_W'(1);
                    end
                end
                ST_BURST: if (hs) begin
                    data_d = adv;
                    beat_d = beat_q + 32'd1;
                    bcnt_d = bcnt_q + BCNT_W'(1);
                    if (bcnt_q == BURST_LAST) state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    flags_d  = flags_q + FLAG_W'(1);
                    status_d = {status_q[STATUS_W-2:0], ^data_q};
                    if (&flags_q) begin
                        if (loop_en) begin
                            state_d = ST_ARM;
                            arm_d   = ARM_LOAD;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            arm_q    <= '0;
            bcnt_q   <= '0;
            data_q   <= '0;
            flags_q  <= '0;
            status_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            arm_q    <= arm_d;
            bcnt_q   <= bcnt_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
            status_q <= status_d;
            beat_q   <= beat_d;
        end
    end

    assign out_if.out_valid = (state_q == ST_BURST);
    assign out_if.out_data  = data_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign flags            = flags_q;
    assign status           = status_q;
    assign beat_cnt         = beat_q;

    stim_clk_div #(.DIV_STAGES(DIV_STAGES)) u_clk_div (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .div_clk (div_clk)
    );
endmodule
